// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states,
// legal parameter ranges and a parity helper. Reused by the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Parity over a zero-extended payload; zero padding does not change the XOR.
    function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] d,
                                         input int mode);
        return (mode == int'(PAR_EVEN)) ? (^d) : ~(^d);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   en   - count enable (frame in progress)
//   clr  - hold the counter at zero
//   div  - bit period minus one, in clk cycles
//   tick - high on the last clock of each bit period while enabled
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    assign tick = en && (cnt == div);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a runtime baud divisor.
// Ports:
//   i_clk        - clock, rising edge
//   rst          - synchronous active-high reset
//   i_baud_div   - bit period minus one (latched at accept)
//   i_tx_start   - send request, only looked at in IDLE
//   i_data       - payload, sent LSB first (latched at accept)
//   o_tx_serial  - serial line, idle high
//   o_tx_busy    - frame in progress
//   o_tx_done    - one-cycle pulse after the last stop bit
//   o_tick_debug - last clock of every bit period
// Handshake: a frame is accepted on any edge where the FSM is IDLE and
// i_tx_start is high; busy rises the next cycle and stays high until the
// cycle in which done pulses. Requests while busy are dropped.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     i_baud_div,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx_serial,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_tick_debug
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS out of range");
    end
    if (PARITY < int'(PAR_NONE) || PARITY > int'(PAR_EVEN)) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS out of range");
    end

    tx_state_e            state;
    tx_state_e            state_nxt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [DIV_W-1:0]     div_q;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 done_q;
    logic                 done_nxt;
    logic                 busy;
    logic                 accept;
    logic                 tick;
    logic                 last_data;
    logic                 last_stop;

    assign busy      = (state != TX_IDLE);
    assign accept    = (state == TX_IDLE) && i_tx_start;
    assign last_data = (bit_idx == 4'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    // Counter is held at zero while idle so the start bit always gets a full period.
    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk (i_clk),
        .rst (rst),
        .en  (busy),
        .clr (!busy),
        .div (div_q),
        .tick(tick)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            TX_IDLE: begin
                if (i_tx_start) state_nxt = TX_START;
            end
            TX_START: begin
                if (tick) state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (tick && last_data) state_nxt = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                if (tick) state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tick && last_stop) begin
                    state_nxt = TX_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            shift_q  <= '0;
            par_q    <= 1'b0;
            div_q    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (accept) begin
                shift_q  <= i_data;
                par_q    <= calc_parity(DATA_BITS_MAX'(i_data), PARITY);
                div_q    <= i_baud_div;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else if (tick) begin
                // Payload leaves from bit 0 of a right-shifting register.
                if (state == TX_DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + 4'd1;
                end
                if (state == TX_STOP) begin
                    stop_idx <= stop_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_tx_serial = 1'b1;
        case (state)
            TX_START:  o_tx_serial = 1'b0;
            TX_DATA:   o_tx_serial = shift_q[0];
            TX_PARITY: o_tx_serial = par_q;
            default:   o_tx_serial = 1'b1;
        endcase
    end

    assign o_tx_busy    = busy;
    assign o_tx_done    = done_q;
    assign o_tick_debug = tick;

endmodule
